// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/enable/strobe decode and frame-derived tick.
module vga_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int FRAMES_PER_TICK = 60
) (
    input  logic       CLOCK_25,
    input  logic       iRST,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic       oHS,
    output logic       oVS,
    output logic       oDE,
    output logic       oLineStart,
    output logic       oFrameStart,
    output logic [7:0] oFrameCnt,
    output logic       oTick
);
    localparam logic [9:0] H_TOTAL = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [7:0] T_LAST  = 8'(FRAMES_PER_TICK - 1);

    logic       run_q;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d, tick_q, tick_d;
    logic [7:0] fcnt_q, fcnt_d, tcnt_q, tcnt_d;
    logic       h_wrap;

    // run_q holds the counters at (0,0) for the first cycle after reset so that pixel is presented
    always_comb begin
        h_wrap = h_q == H_TOTAL - 10'd1;
        h_d    = run_q && !h_wrap ? h_q + 10'd1 : 10'd0;
        v_d    = !(run_q && h_wrap) ? v_q : (v_q == V_TOTAL - 10'd1 ? 10'd0 : v_q + 10'd1);
        ls_d   = h_d == 10'd0;
        fs_d   = ls_d && v_d == 10'd0;
        hs_d   = !(h_d >= HS_BEG && h_d < HS_END);
        vs_d   = !(v_d >= VS_BEG && v_d < VS_END);
        de_d   = h_d < H_ACT && v_d < V_ACT;
        fcnt_d = fcnt_q + 8'(fs_d);
        tick_d = fs_d && tcnt_q == T_LAST;
        tcnt_d = !fs_d ? tcnt_q : (tick_d ? 8'd0 : tcnt_q + 8'd1);
    end

    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            run_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            de_q   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            tick_q <= 1'b0;
            fcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            run_q  <= 1'b1;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            tick_q <= tick_d;
            fcnt_q <= fcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign oX          = h_q;
    assign oY          = v_q;
    assign oHS         = hs_q;
    assign oVS         = vs_q;
    assign oDE         = de_q;
    assign oLineStart  = ls_q;
    assign oFrameStart = fs_q;
    assign oFrameCnt   = fcnt_q;
    assign oTick       = tick_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a reduced-geometry and a full-geometry generator against a cycle-count model.
module tb_vga_timing_gen;
    localparam int SFT = 16 * 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0, n_bad = 0;
    int   mt = -1;

    logic [9:0] sx, sy, bx, by;
    logic       shs, svs, sde, sls, sfs, stk, bhs, bvs, bde, bls, bfs, btk;
    logic [7:0] scnt, bcnt;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .FRAMES_PER_TICK(3)) u_s (
        .CLOCK_25(clk), .iRST(rst), .oX(sx), .oY(sy), .oHS(shs), .oVS(svs), .oDE(sde),
        .oLineStart(sls), .oFrameStart(sfs), .oFrameCnt(scnt), .oTick(stk));

    vga_timing_gen u_b (
        .CLOCK_25(clk), .iRST(rst), .oX(bx), .oY(by), .oHS(bhs), .oVS(bvs), .oDE(bde),
        .oLineStart(bls), .oFrameStart(bfs), .oFrameCnt(bcnt), .oTick(btk));

    always #5 clk = ~clk;

    // mt counts cycles since the last reset release; -1 while reset is applied
    always @(posedge clk) mt <= rst ? -1 : mt + 1;

    function automatic logic [33:0] model(int t, int ha, int hf, int hw, int hb,
                                          int va, int vf, int vw, int vb, int f);
        int ht, vt, x, y, fr;
        logic fs;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        if (t < 0) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        x  = t % ht;
        y  = (t / ht) % vt;
        fr = t / (ht * vt) + 1;
        fs = x == 0 && y == 0;
        return {10'(x), 10'(y), !(x >= ha + hf && x < ha + hf + hw), !(y >= va + vf && y < va + vf + vw),
                x < ha && y < va, x == 0, fs, 8'(fr % 256), fs && fr % f == 0};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %h want %h", name, mt, act, exp);
        end
    endtask

    int s_de, s_vs, b_hs, b_de;

    always @(negedge clk) begin
        chk("small", {sx, sy, shs, svs, sde, sls, sfs, scnt, stk}, model(mt, 8, 2, 3, 3, 6, 1, 2, 2, 3));
        chk("big", {bx, by, bhs, bvs, bde, bls, bfs, bcnt, btk}, model(mt, 640, 16, 96, 48, 480, 10, 2, 33, 60));
        if (mt == -1) chk("rst_vals", {sx, sy, shs, svs, sde, sfs, sls, scnt}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        if (mt == 0) chk("first", {sx, sy, sde, sfs, sls, scnt}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd1});
        if (mt == 8) chk("s_de_fall", 34'(sde), 34'd0);
        if (mt == 10) chk("s_hs_fall", 34'(shs), 34'd0);
        if (mt == 13) chk("s_hs_rise", 34'(shs), 34'd1);
        if (mt == 95) chk("s_last_act", {sx, sy}, {10'd15, 10'd5});
        if (mt == 96) chk("s_blank_line", {sx, sy, sde}, {10'd0, 10'd6, 1'b0});
        if (mt == 112) chk("s_vs_fall", {sx, sy, svs}, {10'd0, 10'd7, 1'b0});
        if (mt == 144) chk("s_vs_rise", 34'(svs), 34'd1);
        if (mt == 175) chk("s_frame_end", {sx, sy}, {10'd15, 10'd10});
        if (mt == SFT) chk("s_wrap", {sx, sy, sfs, scnt, stk}, {10'd0, 10'd0, 1'b1, 8'd2, 1'b0});
        if (mt == SFT) chk("s_runs", {17'(s_de), 17'(s_vs)}, {17'd48, 17'd32});
        if (mt == 2 * SFT) chk("s_tick3", {sfs, stk}, 34'b11);
        if (mt == 254 * SFT) chk("s_cnt255", 34'(scnt), 34'd255);
        if (mt == 255 * SFT) chk("s_cnt_wrap", {sfs, scnt}, {1'b1, 8'd0});
        if (mt == 640) chk("b_de_fall", {bx, bde, bhs}, {10'd640, 1'b0, 1'b1});
        if (mt == 656) chk("b_hs_fall", {bx, bhs}, {10'd656, 1'b0});
        if (mt == 752) chk("b_hs_rise", 34'(bhs), 34'd1);
        if (mt == 800) chk("b_line2", {bx, by, bls}, {10'd0, 10'd1, 1'b1});
        if (mt == 800) chk("b_runs", {17'(b_hs), 17'(b_de)}, {17'd96, 17'd640});
        if (mt <= 0) {s_de, s_vs, b_hs, b_de} = '0;
        if (mt >= 0 && mt < SFT) begin
            s_de += int'(sde);
            s_vs += int'(!svs);
        end
        if (mt >= 0 && mt < 800) begin
            b_hs += int'(!bhs);
            b_de += int'(bde);
        end
    end

    initial begin
        bit found;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (SFT * 258) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < SFT && !found; i++) begin
            @(negedge clk);
            found = sx == 10'd5 && sy == 10'd3;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL mid_reset_point: got no x=5,y=3 want x=5,y=3");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
